sram_march_bist_ctrl: RTL

//  Built-in self-test sequencer for one sram22 macro (1-cycle read latency, byte wmask).

---
 rtl/sram_bist_pkg.sv | 47 ++++
 rtl/sram_march_bist_ctrl_if.sv | 38 +++
 rtl/sram_bist_checker.sv | 85 ++++++++
 rtl/sram_march_bist_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
`default_nettype none
// ============================================================================
// sram_bist_pkg
// March C- element tables, FSM state encoding and command helpers.
// Revision: 1.0
// ============================================================================
package sram_bist_pkg;

  localparam int MARCH_OPS_PER_WORD = 10;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } march_elem_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // Bit e of each table describes March element e.
  localparam logic [5:0] ELEM_DOWN    = 6'b01_1000;
  localparam logic [5:0] ELEM_TWO_OPS = 6'b01_1110;
  localparam logic [5:0] ELEM_RD_POL  = 6'b01_0100;
  localparam logic [5:0] ELEM_WR_POL  = 6'b00_1010;

  // Every element except M0 starts with a read; two-op elements end with a write.
  function automatic logic op_is_read(march_elem_e e, logic op);
    return !op && (e != M0);
  endfunction

  function automatic logic op_is_last(march_elem_e e, logic op);
    return op || !ELEM_TWO_OPS[e];
  endfunction

  function automatic logic op_polarity(march_elem_e e, logic op);
    return op_is_read(e, op) ? ELEM_RD_POL[e] : ELEM_WR_POL[e];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_march_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// sram_march_bist_ctrl_if
// CSR handshake and sram22 macro pins of the March BIST sequencer.
// Revision: 1.0
// ============================================================================
interface sram_march_bist_ctrl_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4
);
  logic                   start;
  logic [DATA_WIDTH-1:0]  bg;
  logic                   busy;
  logic                   done;
  logic                   fail;
  logic [ADDR_WIDTH-1:0]  fail_addr;
  logic [2:0]             fail_elem;
  logic [DATA_WIDTH-1:0]  fail_data;
  logic                   sram_we;
  logic [WMASK_WIDTH-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0]  sram_addr;
  logic [DATA_WIDTH-1:0]  sram_din;
  logic [DATA_WIDTH-1:0]  sram_dout;

  modport master (
    input  start, bg, sram_dout,
    output busy, done, fail, fail_addr, fail_elem, fail_data,
           sram_we, sram_wmask, sram_addr, sram_din
  );

  modport slave (
    output start, bg, sram_dout,
    input  busy, done, fail, fail_addr, fail_elem, fail_data,
           sram_we, sram_wmask, sram_addr, sram_din
  );
endinterface
`default_nettype wire

// File: rtl/sram_bist_checker.sv
`default_nettype none
// ============================================================================
// sram_bist_checker
// Two-stage read-compare pipeline with first-failure syndrome latch.
// Revision: 1.0
// ============================================================================
module sram_bist_checker
  import sram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  issue,
  input  logic [DATA_WIDTH-1:0] issue_exp,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  march_elem_e           issue_elem,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  mismatch,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data
);

  logic                  r_s0_valid, r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s0_exp, r_s1_exp;
  logic [ADDR_WIDTH-1:0] r_s0_addr, r_s1_addr;
  march_elem_e           r_s0_elem, r_s1_elem;
  logic                  r_fail;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [2:0]            r_fail_elem;
  logic [DATA_WIDTH-1:0] r_fail_data;
  logic [DATA_WIDTH-1:0] w_syndrome;

  // Stage 0 tracks the read on the pins, stage 1 the read whose data is on dout.
  assign w_syndrome = dout ^ r_s1_exp;
  assign mismatch   = r_s1_valid && (w_syndrome != '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s0_exp   <= '0;
      r_s1_exp   <= '0;
      r_s0_addr  <= '0;
      r_s1_addr  <= '0;
      r_s0_elem  <= M0;
      r_s1_elem  <= M0;
    end else begin
      // A mismatch ends the test: the read still in flight is discarded.
      r_s0_valid <= issue && !mismatch;
      r_s1_valid <= r_s0_valid && !mismatch;
      r_s0_exp   <= issue_exp;
      r_s1_exp   <= r_s0_exp;
      r_s0_addr  <= issue_addr;
      r_s1_addr  <= r_s0_addr;
      r_s0_elem  <= issue_elem;
      r_s1_elem  <= r_s0_elem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
      r_fail_data <= '0;
    end else if (mismatch && !r_fail) begin
      r_fail      <= 1'b1;
      r_fail_addr <= r_s1_addr;
      r_fail_elem <= r_s1_elem;
      r_fail_data <= w_syndrome;
    end
  end

  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_elem = r_fail_elem;
  assign fail_data = r_fail_data;

endmodule
`default_nettype wire

// File: rtl/sram_march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// sram_march_bist_ctrl
// March C- BIST sequencer for one sram22 macro, one command per cycle.
// Revision: 1.0
// ============================================================================
module sram_march_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_march_bist_ctrl_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

  bist_state_e            r_state, w_state_nxt;
  march_elem_e            r_elem, w_elem_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nxt;
  logic                   r_op, w_op_nxt;
  logic [DATA_WIDTH-1:0]  r_bg, w_bg_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_we, w_we_nxt;
  logic [WMASK_WIDTH-1:0] r_wmask, w_wmask_nxt;
  logic [DATA_WIDTH-1:0]  r_din, w_din_nxt;

  march_elem_e            w_seq_elem;
  logic [ADDR_WIDTH-1:0]  w_seq_addr;
  logic                   w_seq_op;
  logic                   w_seq_rd;
  logic [DATA_WIDTH-1:0]  w_seq_data;
  logic                   w_last_cmd;
  logic                   w_issue_rd;
  logic                   w_clear;
  logic                   w_mismatch;
  logic                   w_fail;
  logic [ADDR_WIDTH-1:0]  w_fail_addr;
  logic [2:0]             w_fail_elem;
  logic [DATA_WIDTH-1:0]  w_fail_data;

  // Successor of the command currently on the pins; wrap is a compare, not a carry.
  always_comb begin
    w_seq_elem = r_elem;
    w_seq_addr = r_addr;
    w_seq_op   = 1'b0;
    if (!op_is_last(r_elem, r_op)) begin
      w_seq_op = 1'b1;
    end else if (r_addr == (ELEM_DOWN[r_elem] ? ADDR_ZERO : ADDR_MAX)) begin
      w_seq_elem = (r_elem == M5) ? M5 : march_elem_e'(r_elem + 3'd1);
      w_seq_addr = ELEM_DOWN[w_seq_elem] ? ADDR_MAX : ADDR_ZERO;
    end else begin
      w_seq_addr = ELEM_DOWN[r_elem] ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
    end
  end

  assign w_last_cmd = (r_elem == M5) && (r_addr == ADDR_MAX);
  assign w_seq_rd   = op_is_read(w_seq_elem, w_seq_op);
  assign w_seq_data = op_polarity(w_seq_elem, w_seq_op) ? ~r_bg : r_bg;

  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_addr_nxt  = r_addr;
    w_op_nxt    = r_op;
    w_bg_nxt    = r_bg;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_we_nxt    = 1'b0;
    w_wmask_nxt = '0;
    w_din_nxt   = '0;
    w_issue_rd  = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          // First command is M0 w0 at address 0 using the freshly sampled bg.
          w_state_nxt = ST_RUN;
          w_elem_nxt  = M0;
          w_addr_nxt  = ADDR_ZERO;
          w_op_nxt    = 1'b0;
          w_bg_nxt    = bus.bg;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_we_nxt    = 1'b1;
          w_wmask_nxt = '1;
          w_din_nxt   = bus.bg;
          w_clear     = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_mismatch) begin
          w_state_nxt = ST_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (w_last_cmd) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_elem_nxt  = w_seq_elem;
          w_addr_nxt  = w_seq_addr;
          w_op_nxt    = w_seq_op;
          w_we_nxt    = !w_seq_rd;
          w_wmask_nxt = w_seq_rd ? '0 : '1;
          w_din_nxt   = w_seq_rd ? '0 : w_seq_data;
          w_issue_rd  = w_seq_rd;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_DONE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_elem  <= M0;
      r_addr  <= '0;
      r_op    <= 1'b0;
      r_bg    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_wmask <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      r_addr  <= w_addr_nxt;
      r_op    <= w_op_nxt;
      r_bg    <= w_bg_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_we    <= w_we_nxt;
      r_wmask <= w_wmask_nxt;
      r_din   <= w_din_nxt;
    end
  end

  sram_bist_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_clear),
    .issue      (w_issue_rd),
    .issue_exp  (w_seq_data),
    .issue_addr (w_seq_addr),
    .issue_elem (w_seq_elem),
    .dout       (bus.sram_dout),
    .mismatch   (w_mismatch),
    .fail       (w_fail),
    .fail_addr  (w_fail_addr),
    .fail_elem  (w_fail_elem),
    .fail_data  (w_fail_data)
  );

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.fail       = w_fail;
  assign bus.fail_addr  = w_fail_addr;
  assign bus.fail_elem  = w_fail_elem;
  assign bus.fail_data  = w_fail_data;
  assign bus.sram_we    = r_we;
  assign bus.sram_wmask = r_wmask;
  assign bus.sram_addr  = r_addr;
  assign bus.sram_din   = r_din;

endmodule
`default_nettype wire
